// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM wrapper among NUM_REQ requesters.
// Commands are registered, reads get a hold cycle, and read data is routed back by requester id.
module sram_port_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int DATA_BIT = 64,
    parameter int DEPTH    = 512,
    parameter int ADDR_BIT = $clog2(DEPTH),
    parameter int ID_BIT   = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ-1:0]           req_wen,
    input  logic [NUM_REQ-1:0]           req_lock,
    input  logic [NUM_REQ*ADDR_BIT-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_BIT-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [DATA_BIT-1:0]          rsp_rdata,
    output logic [ADDR_BIT-1:0]          sram_addr,
    output logic                         sram_wen,
    output logic                         sram_ren,
    output logic [DATA_BIT-1:0]          sram_wdata,
    input  logic [DATA_BIT-1:0]          sram_rdata
);

    localparam int SW = ID_BIT + 1;

    typedef enum logic [1:0] {IDLE, WR, RD, RD_HOLD} state_t;

    state_t              state, state_nxt;
    logic [ID_BIT-1:0]   rr_ptr;
    logic [ID_BIT-1:0]   grant_id;
    logic                grant_found;
    logic                accept_ok;
    logic                handshake;
    logic [SW-1:0]       cand;

    logic [ADDR_BIT-1:0] sel_addr;
    logic [DATA_BIT-1:0] sel_wdata;
    logic                sel_wen;
    logic                sel_lock;

    logic [ADDR_BIT-1:0] cmd_addr;
    logic [DATA_BIT-1:0] cmd_wdata;
    logic                cmd_wen;
    logic [ID_BIT-1:0]   cmd_id;

    logic                p1_valid, p2_valid;
    logic [ID_BIT-1:0]   p1_id, p2_id;

    // Search from rr_ptr upward, wrapping at NUM_REQ, for the first valid requester.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + SW'(k);
            if (cand >= SW'(NUM_REQ))
                cand = cand - SW'(NUM_REQ);
            if (!grant_found && req_valid[cand[ID_BIT-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = cand[ID_BIT-1:0];
            end
        end
    end

    // RD is the one cycle where the SRAM port cannot take a new command.
    assign accept_ok = (state != RD) && !rst;
    assign handshake = accept_ok && grant_found;

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wen   = 1'b0;
        sel_lock  = 1'b0;
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == ID_BIT'(i)) begin
                sel_addr  = req_addr[i*ADDR_BIT +: ADDR_BIT];
                sel_wdata = req_wdata[i*DATA_BIT +: DATA_BIT];
                sel_wen   = req_wen[i];
                sel_lock  = req_lock[i];
                req_ready[i] = handshake;
            end
        end
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            RD:      state_nxt = RD_HOLD;
            default: state_nxt = handshake ? (sel_wen ? WR : RD) : IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            cmd_wen   <= 1'b0;
            cmd_id    <= '0;
            p1_valid  <= 1'b0;
            p1_id     <= '0;
            p2_valid  <= 1'b0;
            p2_id     <= '0;
        end else begin
            state <= state_nxt;
            if (handshake) begin
                cmd_addr  <= sel_addr;
                cmd_wdata <= sel_wdata;
                cmd_wen   <= sel_wen;
                cmd_id    <= grant_id;
                if (sel_lock)
                    rr_ptr <= grant_id;
                else if (grant_id == ID_BIT'(NUM_REQ-1))
                    rr_ptr <= '0;
                else
                    rr_ptr <= grant_id + ID_BIT'(1);
            end
            // Response tag launches out of RD so it lines up with data after RD_HOLD.
            p1_valid <= (state == RD);
            p1_id    <= cmd_id;
            p2_valid <= p1_valid;
            p2_id    <= p1_id;
        end
    end

    assign sram_addr  = cmd_addr;
    assign sram_wdata = cmd_wdata;
    assign sram_wen   = (state == WR) && cmd_wen;
    assign sram_ren   = ((state == RD) || (state == RD_HOLD)) && !cmd_wen;

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++)
            rsp_valid[i] = p2_valid && (p2_id == ID_BIT'(i));
    end

    assign rsp_rdata = sram_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural registered-read SRAM model.
// Covers reset, round-robin, lock, write/read, back-to-back reads, hazard and mid-read reset.
module tb_sram_port_arbiter;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int AW = 9;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_wen = '0;
    logic [N-1:0]    req_lock = '0;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic [AW-1:0]   sram_addr;
    logic            sram_wen;
    logic            sram_ren;
    logic [DW-1:0]   sram_wdata;
    logic [DW-1:0]   sram_rdata;

    logic [AW-1:0]   addr_tab [N];
    logic [DW-1:0]   wdata_tab [N];
    logic [DW-1:0]   mem [0:511];

    int pass_count = 0;
    int total_count = 0;

    typedef struct {
        logic       rst;
        logic [3:0] valid;
        logic [3:0] wen;
        logic [3:0] lock;
        logic [3:0] exp_ready;
        logic       exp_wen;
        logic       exp_ren;
        logic [8:0] exp_addr;
        logic [3:0] exp_rsp;
    } vec_t;

    vec_t tab [17];

    sram_port_arbiter #(.NUM_REQ(N), .DATA_BIT(DW), .DEPTH(512)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wen    (req_wen),
        .req_lock   (req_lock),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .sram_addr  (sram_addr),
        .sram_wen   (sram_wen),
        .sram_ren   (sram_ren),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW]  = addr_tab[i];
            req_wdata[i*DW +: DW] = wdata_tab[i];
        end
    end

    // Registered-read SRAM: data from a read cycle appears in the following cycle.
    always @(posedge clk) begin
        if (sram_wen)
            mem[sram_addr] <= sram_wdata;
        else if (sram_ren)
            sram_rdata <= mem[sram_addr];
    end

    task automatic applyStimulus(input logic r, input logic [3:0] v, input logic [3:0] w,
                                 input logic [3:0] l);
        @(posedge clk);
        #1;
        rst       = r;
        req_valid = v;
        req_wen   = w;
        req_lock  = l;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_count++;
        if (act !== exp)
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        else
            pass_count++;
    endtask

    initial begin
        logic [3:0] exp_ready;
        logic [3:0] exp_rsp;
        logic [8:0] exp_addr;

        for (int i = 0; i < N; i++) begin
            addr_tab[i]  = 9'h040 + 9'(i);
            wdata_tab[i] = 64'h1000 + 64'(i);
        end

        tab[0]  = '{1'b1, 4'hF, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 9'h000, 4'h0};
        tab[1]  = '{1'b0, 4'hF, 4'hF, 4'h0, 4'h1, 1'b0, 1'b0, 9'h000, 4'h0};
        tab[2]  = '{1'b0, 4'hF, 4'hF, 4'h0, 4'h2, 1'b1, 1'b0, 9'h040, 4'h0};
        tab[3]  = '{1'b0, 4'hF, 4'hF, 4'h0, 4'h4, 1'b1, 1'b0, 9'h041, 4'h0};
        tab[4]  = '{1'b0, 4'hF, 4'hF, 4'h0, 4'h8, 1'b1, 1'b0, 9'h042, 4'h0};
        tab[5]  = '{1'b0, 4'hF, 4'hF, 4'h0, 4'h1, 1'b1, 1'b0, 9'h043, 4'h0};
        tab[6]  = '{1'b0, 4'hF, 4'hF, 4'h0, 4'h2, 1'b1, 1'b0, 9'h040, 4'h0};
        tab[7]  = '{1'b0, 4'hF, 4'hF, 4'h0, 4'h4, 1'b1, 1'b0, 9'h041, 4'h0};
        tab[8]  = '{1'b0, 4'hF, 4'hF, 4'h0, 4'h8, 1'b1, 1'b0, 9'h042, 4'h0};
        tab[9]  = '{1'b0, 4'h8, 4'hF, 4'h8, 4'h8, 1'b1, 1'b0, 9'h043, 4'h0};
        tab[10] = '{1'b0, 4'h9, 4'hF, 4'h8, 4'h8, 1'b1, 1'b0, 9'h043, 4'h0};
        tab[11] = '{1'b0, 4'h9, 4'hF, 4'h8, 4'h8, 1'b1, 1'b0, 9'h043, 4'h0};
        tab[12] = '{1'b0, 4'h9, 4'hF, 4'h8, 4'h8, 1'b1, 1'b0, 9'h043, 4'h0};
        tab[13] = '{1'b0, 4'h9, 4'hF, 4'h8, 4'h8, 1'b1, 1'b0, 9'h043, 4'h0};
        tab[14] = '{1'b0, 4'h1, 4'hF, 4'h0, 4'h1, 1'b1, 1'b0, 9'h043, 4'h0};
        tab[15] = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 9'h040, 4'h0};
        tab[16] = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 9'h040, 4'h0};

        applyStimulus(1'b1, 4'h0, 4'h0, 4'h0);
        applyStimulus(1'b1, 4'h0, 4'h0, 4'h0);

        // Reset, round-robin writes, then a locked burst from r3.
        for (int r = 0; r < 17; r++) begin
            applyStimulus(tab[r].rst, tab[r].valid, tab[r].wen, tab[r].lock);
            checkOutput($sformatf("tab%0d_ready", r), 64'(req_ready), 64'(tab[r].exp_ready));
            checkOutput($sformatf("tab%0d_wen", r), 64'(sram_wen), 64'(tab[r].exp_wen));
            checkOutput($sformatf("tab%0d_ren", r), 64'(sram_ren), 64'(tab[r].exp_ren));
            checkOutput($sformatf("tab%0d_addr", r), 64'(sram_addr), 64'(tab[r].exp_addr));
            checkOutput($sformatf("tab%0d_rsp", r), 64'(rsp_valid), 64'(tab[r].exp_rsp));
            if (r == 0)
                checkOutput("reset_wdata", sram_wdata, 64'h0);
        end

        // r0 writes 0x05 then reads it back.
        addr_tab[0]  = 9'h005;
        wdata_tab[0] = 64'hA5A5;
        applyStimulus(1'b0, 4'b0001, 4'b0001, 4'h0);
        checkOutput("wr_ready", 64'(req_ready), 64'h1);
        applyStimulus(1'b0, 4'b0001, 4'b0000, 4'h0);
        checkOutput("wr_ready_rd", 64'(req_ready), 64'h1);
        checkOutput("wr_sram_wen", 64'(sram_wen), 64'h1);
        checkOutput("wr_sram_ren", 64'(sram_ren), 64'h0);
        checkOutput("wr_sram_addr", 64'(sram_addr), 64'h005);
        checkOutput("wr_sram_wdata", sram_wdata, 64'hA5A5);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 4'h0);
        checkOutput("rd_ren", 64'(sram_ren), 64'h1);
        checkOutput("rd_wen", 64'(sram_wen), 64'h0);
        checkOutput("rd_addr", 64'(sram_addr), 64'h005);
        checkOutput("rd_rsp", 64'(rsp_valid), 64'h0);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 4'h0);
        checkOutput("hold_ren", 64'(sram_ren), 64'h1);
        checkOutput("hold_addr", 64'(sram_addr), 64'h005);
        checkOutput("hold_rsp", 64'(rsp_valid), 64'h0);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 4'h0);
        checkOutput("rsp_valid", 64'(rsp_valid), 64'h1);
        checkOutput("rsp_rdata", rsp_rdata, 64'hA5A5);
        checkOutput("idle_ren", 64'(sram_ren), 64'h0);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 4'h0);
        checkOutput("rsp_one_cycle", 64'(rsp_valid), 64'h0);

        // Preload 0x10/0x20 through r1/r2, then both read continuously.
        addr_tab[1]  = 9'h010;
        wdata_tab[1] = 64'h1111_2222_3333_4444;
        addr_tab[2]  = 9'h020;
        wdata_tab[2] = 64'h5555_6666_7777_8888;
        applyStimulus(1'b0, 4'b0110, 4'b0110, 4'h0);
        applyStimulus(1'b0, 4'b0110, 4'b0110, 4'h0);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 4'h0);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 4'h0);
        for (int t = 0; t < 12; t++) begin
            applyStimulus(1'b0, (t < 10) ? 4'b0110 : 4'b0000, 4'h0, 4'h0);
            exp_ready = 4'h0;
            if (t == 0)
                exp_ready = 4'b0010;
            else if (t < 10 && (t % 2) == 0)
                exp_ready = ((t % 4) == 2) ? 4'b0100 : 4'b0010;
            checkOutput($sformatf("b2b%0d_ready", t), 64'(req_ready), 64'(exp_ready));
            if (t >= 1 && t <= 10) begin
                exp_addr = ((((t - 1) / 2) % 2) == 0) ? 9'h010 : 9'h020;
                checkOutput($sformatf("b2b%0d_ren", t), 64'(sram_ren), 64'h1);
                checkOutput($sformatf("b2b%0d_addr", t), 64'(sram_addr), 64'(exp_addr));
            end
            exp_rsp = 4'h0;
            if (t >= 3 && (t % 2) == 1)
                exp_rsp = ((t % 4) == 3) ? 4'b0010 : 4'b0100;
            checkOutput($sformatf("b2b%0d_rsp", t), 64'(rsp_valid), 64'(exp_rsp));
            if (exp_rsp == 4'b0010)
                checkOutput($sformatf("b2b%0d_data", t), rsp_rdata, 64'h1111_2222_3333_4444);
            else if (exp_rsp == 4'b0100)
                checkOutput($sformatf("b2b%0d_data", t), rsp_rdata, 64'h5555_6666_7777_8888);
        end

        // r2 writes 0x1FF, r0 reads 0x1FF in the very next accepted command.
        addr_tab[2]  = 9'h1FF;
        wdata_tab[2] = 64'hDEAD;
        addr_tab[0]  = 9'h1FF;
        applyStimulus(1'b0, 4'b0100, 4'b0100, 4'h0);
        checkOutput("haz_wr_ready", 64'(req_ready), 64'h4);
        applyStimulus(1'b0, 4'b0001, 4'b0000, 4'h0);
        checkOutput("haz_rd_ready", 64'(req_ready), 64'h1);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 4'h0);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 4'h0);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 4'h0);
        checkOutput("haz_rsp", 64'(rsp_valid), 64'h1);
        checkOutput("haz_data", rsp_rdata, 64'hDEAD);

        // r0 read, then reset lands in RD_HOLD: response must be dropped.
        addr_tab[0] = 9'h005;
        applyStimulus(1'b0, 4'b0001, 4'b0000, 4'h0);
        checkOutput("rst_rd_ready", 64'(req_ready), 64'h1);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 4'h0);
        applyStimulus(1'b1, 4'b1111, 4'b1111, 4'h0);
        checkOutput("rst_ready_zero", 64'(req_ready), 64'h0);
        applyStimulus(1'b0, 4'b1111, 4'b1111, 4'h0);
        checkOutput("rst_no_rsp", 64'(rsp_valid), 64'h0);
        checkOutput("rst_wen", 64'(sram_wen), 64'h0);
        checkOutput("rst_ren", 64'(sram_ren), 64'h0);
        checkOutput("rst_addr", 64'(sram_addr), 64'h0);
        checkOutput("rst_wdata", sram_wdata, 64'h0);
        checkOutput("rst_ptr_zero", 64'(req_ready), 64'h1);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 4'h0);
        checkOutput("rst_no_rsp_late", 64'(rsp_valid), 64'h0);

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule
